fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Shares the push side of one FIFO instance (fifo / fifo_v2 style: push, data, full, flush) among NUM_REQ requesters.
- Arbitration is round-robin, with bursts locked to one requester until the requester marks the last beat.
- Sequences FIFO flushes so that a flush never splits a burst.
- Sits between producer ports and the shared FIFO. The pop side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, width of each beat and of the FIFO data.
- IDX_W, $clog2(NUM_REQ), derived width of the grant index. Not user-set.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed beats; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  beat is the last of its burst.
- req_ready_o  out  NUM_REQ  beat accepted this cycle when valid&ready.
- fifo_full_i  in  1  FIFO full_o.
- fifo_push_o  out  1  to FIFO push_i.
- fifo_data_o  out  DATA_WIDTH  to FIFO data_i.
- fifo_flush_o  out  1  to FIFO flush_i.
- flush_req_i  in  1  request a flush (level or pulse).
- flush_done_o  out  1  one-cycle pulse when the flush was issued.
- grant_valid_o  out  1  a requester currently holds the grant.
- grant_idx_o  out  IDX_W  index of the granted requester.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, rr_ptr=0, flush_pend=0.
  - All outputs 0 the following cycle.
  - Reset mid-burst abandons the lock; the partial burst stays in the FIFO.
- Handshake is zero latency and combinational:
  - fifo_push_o = grant_valid_o & req_valid_i[g] & ~fifo_full_i.
  - req_ready_o[g] = grant_valid_o & ~fifo_full_i. All other ready bits are 0.
  - fifo_data_o = beat of g when granted, else 0.
- Valid/data rules for requesters:
  - Valid must not drop once raised until accepted.
  - Data must stay stable until accepted.
  - The arbiter does not depend on this rule for correctness.
- States: IDLE, LOCKED, FLUSH.
- IDLE:
  - If flush_pend=1, grant nothing and go to FLUSH.
  - Otherwise the winner is the first k with req_valid_i[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - grant_valid_o=1 and grant_idx_o=winner in the same cycle.
  - Transfer with last=1: stay IDLE, rr_ptr <= winner+1 (wraps NUM_REQ-1 -> 0).
  - Transfer with last=0: go to LOCKED, lock_idx <= winner.
  - No transfer (FIFO full): stay IDLE, rr_ptr unchanged, re-arbitrate next cycle. The grant is not sticky.
- LOCKED:
  - grant_idx_o=lock_idx and grant_valid_o=1, even when lock_idx's valid is low.
  - Transfer with last=1: go to IDLE, rr_ptr <= lock_idx+1.
  - fifo_full_i stalls the burst; state is held.
- FLUSH:
  - Entered only from IDLE. Lasts exactly one cycle.
  - fifo_flush_o=1, flush_done_o=1, grant_valid_o=0, all ready bits 0.
  - Exit: clear flush_pend, rr_ptr <= 0, go to IDLE.
- flush_pend:
  - Set on any cycle with flush_req_i=1.
  - A flush request during LOCKED waits for the last beat.
  - flush_req_i in the same cycle as a single-beat IDLE grant: that beat transfers, and FLUSH follows next cycle.
  - flush_req_i held high re-arms flush_pend. A continuous level produces a flush every other cycle.
- Single requester (NUM_REQ=1): rr_ptr is always 0.

Optional Feature:
- Macro: FIFO_PUSH_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats_o, NUM_REQ*16 bits.
  - One 16-bit saturating counter per requester, incremented on each accepted beat and held at 16'hFFFF.
  - Counters clear on rst_i and on FLUSH.
- Undefined: the port and counters do not exist; other behaviour is identical.

Decomposition:
- Package fifo_push_arbiter_pkg:
  - state enum typedef arb_state_e {IDLE, LOCKED, FLUSH}, 2 bits.
  - Constant STAT_W=16.
- One sub-module, fifo_arb_rr_pick:
  - Combinational round-robin search.
  - Inputs: request vector and rr_ptr.
  - Outputs: found and idx.
  - Implementation: double-width vector masked by pointer, then leading-one search.

Test Plan:
- Round-robin: NUM_REQ=4, all four valid with last=1 every beat, FIFO never full -> grant_idx_o sequence 0,1,2,3,0,1 over six cycles, with fifo_push_o=1 each cycle.
- Burst lock: req1 sends a 3-beat burst (last on beat 3) while req0 and req2 stay valid -> three consecutive grants to 1, then grant 2, then 0.
- Backpressure: fifo_full_i=1 for 5 cycles during a LOCKED burst -> fifo_push_o=0, all ready bits 0, grant_idx_o held. Burst resumes on the cycle full drops, with no beat lost or duplicated.
- Flush during burst: flush_req_i pulsed on beat 1 of a 4-beat burst -> no flush until beat 4 transfers, then one cycle with fifo_flush_o=1 and flush_done_o=1, then rr_ptr=0 (req0 wins next).
- Wrap: only req3 valid with single beats, then all valid -> after the req3 grant, the next winner is req0.
- Reset mid-burst: rst_i=1 during LOCKED on req2 -> next cycle state IDLE, all outputs 0, first grant after reset goes to the lowest valid index. With FIFO_PUSH_ARB_STATS_EN defined, counters read 0 and saturate at 65535 after 70000 beats on one requester.

Source files
------------

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types, constants and helpers for the FIFO push-side arbiter.
package fifo_push_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      FLUSH  = 2'd2
   } arb_state_e;

   localparam int STAT_W = 16;

   // Round-robin successor of idx among n requesters; always 0 when n is 1.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping.
module fifo_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] masked;
   int                   pos;

   // The doubled vector turns the wrap-around search into a plain lowest-bit search.
   always_comb begin
      dbl    = {req_i, req_i};
      masked = '0;
      for (int i = 0; i < 2*NUM_REQ; i++) begin
         if (i >= int'(ptr_i)) masked[i] = dbl[i];
      end

      found_o = 1'b0;
      pos     = 0;
      for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
         if (masked[i]) begin
            found_o = 1'b1;
            pos     = i;
         end
      end

      idx_o = IDX_W'((pos >= NUM_REQ) ? pos - NUM_REQ : pos);
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO push port; sequences flushes between bursts.
// Define FIFO_PUSH_ARB_STATS_EN to add per-requester saturating beat counters (stat_beats_o).
module fifo_push_arbiter
   import fifo_push_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 32,
   localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_push_o,
   output logic [DATA_WIDTH-1:0]         fifo_data_o,
   output logic                          fifo_flush_o,
   input  logic                          flush_req_i,
   output logic                          flush_done_o,
   output logic                          grant_valid_o,
   output logic [IDX_W-1:0]              grant_idx_o
`ifdef FIFO_PUSH_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0]     stat_beats_o
`endif
);

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
   logic                   flush_pend_q, flush_pend_d;

   logic                   pick_found;
   logic [IDX_W-1:0]       pick_idx;
   logic                   grant_valid;
   logic [IDX_W-1:0]       grant_idx;
   logic                   beat_valid;
   logic                   beat_last;
   logic [DATA_WIDTH-1:0]  beat_data;
   logic                   push;

   fifo_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // NOTE: every combinational output gets a default before any branch, so no latches are inferred.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      case (state_q)
         IDLE: begin
            if (!flush_pend_q && pick_found) begin
               grant_valid = 1'b1;
               grant_idx   = pick_idx;
            end
         end
         LOCKED: begin
            grant_valid = 1'b1;
            grant_idx   = lock_idx_q;
         end
         default: ;
      endcase

      beat_valid  = 1'b0;
      beat_last   = 1'b0;
      beat_data   = '0;
      req_ready_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (IDX_W'(k) == grant_idx) begin
            beat_valid     = req_valid_i[k];
            beat_last      = req_last_i[k];
            beat_data      = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            req_ready_o[k] = grant_valid & ~fifo_full_i;
         end
      end

      push          = grant_valid & beat_valid & ~fifo_full_i;
      fifo_push_o   = push;
      fifo_data_o   = grant_valid ? beat_data : '0;
      fifo_flush_o  = (state_q == FLUSH);
      flush_done_o  = (state_q == FLUSH);
      grant_valid_o = grant_valid;
      grant_idx_o   = grant_idx;
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      lock_idx_d   = lock_idx_q;
      flush_pend_d = flush_pend_q | flush_req_i;
      case (state_q)
         IDLE: begin
            if (flush_pend_q) begin
               state_d = FLUSH;
            end else if (push) begin
               if (beat_last) begin
                  rr_ptr_d = IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
               end else begin
                  state_d    = LOCKED;
                  lock_idx_d = grant_idx;
               end
            end
         end
         LOCKED: begin
            if (push && beat_last) begin
               state_d  = IDLE;
               rr_ptr_d = IDX_W'(rr_next(32'(lock_idx_q), NUM_REQ));
            end
         end
         FLUSH: begin
            // A request still held high re-arms the flush for the next idle cycle.
            state_d      = IDLE;
            rr_ptr_d     = '0;
            flush_pend_d = flush_req_i;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         lock_idx_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         lock_idx_q   <= lock_idx_d;
         flush_pend_q <= flush_pend_d;
      end
   end

`ifdef FIFO_PUSH_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_REQ];
   logic [STAT_W-1:0] stat_d [NUM_REQ];

   always_comb begin
      stat_beats_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         stat_d[k] = stat_q[k];
         if (state_q == FLUSH) begin
            stat_d[k] = '0;
         end else if (push && (grant_idx == IDX_W'(k)) && (stat_q[k] != '1)) begin
            stat_d[k] = stat_q[k] + STAT_W'(1);
         end
         stat_beats_o[k*STAT_W +: STAT_W] = stat_q[k];
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rst_i) stat_q[k] <= '0;
         else       stat_q[k] <= stat_d[k];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the arbitration rules.
module tb_fifo_push_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic              fifo_full;
   logic              fifo_push;
   logic [DW-1:0]     fifo_data;
   logic              fifo_flush;
   logic              flush_req;
   logic              flush_done;
   logic              grant_valid;
   logic [1:0]        grant_idx;
`ifdef FIFO_PUSH_ARB_STATS_EN
   logic [N*16-1:0]   stat_beats;
`endif

   fifo_push_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_last_i    (req_last),
      .req_ready_o   (req_ready),
      .fifo_full_i   (fifo_full),
      .fifo_push_o   (fifo_push),
      .fifo_data_o   (fifo_data),
      .fifo_flush_o  (fifo_flush),
      .flush_req_i   (flush_req),
      .flush_done_o  (flush_done),
      .grant_valid_o (grant_valid),
      .grant_idx_o   (grant_idx)
`ifdef FIFO_PUSH_ARB_STATS_EN
      ,
      .stat_beats_o  (stat_beats)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state: current burst owner (-1 when none), first requester searched next,
   // flush waiting to be issued, and whether the current cycle is the flush cycle.
   int     m_owner;
   int     m_ptr;
   bit     m_pend;
   bit     m_flush;
   int     cnt [N];

   bit           e_gv;
   int           e_gi;
   bit           e_push;
   logic [N-1:0] e_ready;
   logic [DW-1:0] e_data;
   bit           e_flush;
   logic [N-1:0] acc;

   int lock_seq [5] = '{1, 1, 1, 2, 0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat(input int k);
      return req_data[k*DW +: DW];
   endfunction

   task automatic set_beat(input int k, input bit v, input bit l, input logic [DW-1:0] d);
      req_valid[k]         = v;
      req_last[k]          = l;
      req_data[k*DW +: DW] = d;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      flush_req = 1'b0;
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_pend  = 1'b0;
      m_flush = 1'b0;
      for (int k = 0; k < N; k++) cnt[k] = 0;
   endtask

   task automatic model_eval();
      int k;
      e_gv    = 1'b0;
      e_gi    = 0;
      e_flush = m_flush;
      if (!m_flush) begin
         if (m_owner >= 0) begin
            e_gv = 1'b1;
            e_gi = m_owner;
         end else if (!m_pend) begin
            for (int j = 0; j < N; j++) begin
               k = (m_ptr + j) % N;
               if (!e_gv && req_valid[k]) begin
                  e_gv = 1'b1;
                  e_gi = k;
               end
            end
         end
      end
      e_push  = e_gv && req_valid[e_gi] && !fifo_full;
      e_ready = '0;
      if (e_gv && !fifo_full) e_ready[e_gi] = 1'b1;
      e_data  = e_gv ? beat(e_gi) : '0;
      acc     = e_ready & req_valid;
   endtask

   task automatic model_update();
      bit nf;
      if (rst) begin
         model_reset();
      end else begin
         nf = 1'b0;
         if (m_flush) begin
            m_ptr  = 0;
            m_pend = flush_req;
            for (int k = 0; k < N; k++) cnt[k] = 0;
         end else begin
            if (m_owner < 0 && m_pend) nf = 1'b1;
            if (e_push) begin
               if (cnt[e_gi] < 65535) cnt[e_gi]++;
               if (req_last[e_gi]) begin
                  m_owner = -1;
                  m_ptr   = (e_gi + 1) % N;
               end else begin
                  m_owner = e_gi;
               end
            end
            m_pend = m_pend || flush_req;
         end
         m_flush = nf;
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
   task automatic settle();
      #3;
   endtask

   task automatic advance();
      model_eval();
      check("grant_valid", 64'(grant_valid), 64'(e_gv));
      if (e_gv) check("grant_idx", 64'(grant_idx), 64'(e_gi));
      check("fifo_push", 64'(fifo_push), 64'(e_push));
      check("req_ready", 64'(req_ready), 64'(e_ready));
      check("fifo_data", 64'(fifo_data), 64'(e_data));
      check("fifo_flush", 64'(fifo_flush), 64'(e_flush));
      check("flush_done", 64'(flush_done), 64'(e_flush));
`ifdef FIFO_PUSH_ARB_STATS_EN
      for (int k = 0; k < N; k++) check("stat_beats", 64'(stat_beats[k*16 +: 16]), 64'(cnt[k]));
`endif
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic rand_drive();
      for (int k = 0; k < N; k++) begin
         if (!req_valid[k] || acc[k])
            set_beat(k, $urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0, $urandom);
      end
      fifo_full = $urandom_range(0, 3) == 0;
      flush_req = $urandom_range(0, 15) == 0;
   endtask

   initial begin
      int b;
      int cyc;

      clear_inputs();
      acc = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // Reset state
      settle();
      check("rst_gv", 64'(grant_valid), 64'(0));
      check("rst_push", 64'(fifo_push), 64'(0));
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_flush", 64'(fifo_flush), 64'(0));
      check("rst_data", 64'(fifo_data), 64'(0));
      advance();

      // Round-robin over single-beat requests
      for (int k = 0; k < N; k++) set_beat(k, 1'b1, 1'b1, 32'hA000 + 32'(k));
      for (int i = 0; i < 6; i++) begin
         settle();
         check("rr_idx", 64'(grant_idx), 64'(i % 4));
         check("rr_push", 64'(fifo_push), 64'(1));
         advance();
      end

      // Burst lock: req1 three beats while req0 and req2 wait
      clear_inputs();
      set_beat(0, 1'b1, 1'b1, 32'h100);
      step();
      set_beat(0, 1'b1, 1'b1, 32'h101);
      set_beat(2, 1'b1, 1'b1, 32'h200);
      b = 0;
      for (int i = 0; i < 5; i++) begin
         set_beat(1, b < 3, b == 2, 32'h110 + 32'(b));
         settle();
         check("lock_idx", 64'(grant_idx), 64'(lock_seq[i]));
         advance();
         if (acc[1]) b++;
         if (acc[0]) set_beat(0, 1'b0, 1'b0, '0);
         if (acc[2]) set_beat(2, 1'b0, 1'b0, '0);
      end

      // Backpressure in the middle of a locked burst on req2
      clear_inputs();
      b   = 0;
      cyc = 0;
      while (b < 4 && cyc < 20) begin
         set_beat(2, 1'b1, b == 3, 32'h300 + 32'(b));
         fifo_full = (cyc >= 1 && cyc <= 5);
         settle();
         if (fifo_full) begin
            check("bp_push", 64'(fifo_push), 64'(0));
            check("bp_ready", 64'(req_ready), 64'(0));
            check("bp_gv", 64'(grant_valid), 64'(1));
            check("bp_idx", 64'(grant_idx), 64'(2));
         end
         advance();
         if (acc[2]) b++;
         cyc++;
      end
      fifo_full = 1'b0;
      check("bp_cycles", 64'(cyc), 64'(9));

      // Flush request on beat 1 of a 4-beat burst
      clear_inputs();
      set_beat(1, 1'b1, 1'b1, 32'h150);
      settle();
      check("prep_idx", 64'(grant_idx), 64'(1));
      advance();
      clear_inputs();
      set_beat(0, 1'b1, 1'b1, 32'h400);
      set_beat(3, 1'b1, 1'b1, 32'h430);
      for (int i = 0; i < 4; i++) begin
         set_beat(2, 1'b1, i == 3, 32'h420 + 32'(i));
         flush_req = (i == 0);
         settle();
         check("fl_idx", 64'(grant_idx), 64'(2));
         check("fl_noflush", 64'(fifo_flush), 64'(0));
         advance();
      end
      flush_req = 1'b0;
      set_beat(2, 1'b0, 1'b0, '0);
      settle();
      check("fl_gap_gv", 64'(grant_valid), 64'(0));
      check("fl_gap_flush", 64'(fifo_flush), 64'(0));
      advance();
      settle();
      check("fl_flush", 64'(fifo_flush), 64'(1));
      check("fl_done", 64'(flush_done), 64'(1));
      check("fl_gv", 64'(grant_valid), 64'(0));
      check("fl_ready", 64'(req_ready), 64'(0));
      advance();
      settle();
      check("fl_after_gv", 64'(grant_valid), 64'(1));
      check("fl_after_idx", 64'(grant_idx), 64'(0));
      advance();

      // Wrap from req3 back to req0
      clear_inputs();
      set_beat(3, 1'b1, 1'b1, 32'h530);
      settle();
      check("wrap_idx3", 64'(grant_idx), 64'(3));
      advance();
      for (int k = 0; k < N; k++) set_beat(k, 1'b1, 1'b1, 32'h540 + 32'(k));
      settle();
      check("wrap_idx0", 64'(grant_idx), 64'(0));
      advance();

      // Reset in the middle of a burst on req2
      clear_inputs();
      set_beat(2, 1'b1, 1'b0, 32'h600);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_inputs();
      settle();
      check("mrst_gv", 64'(grant_valid), 64'(0));
      check("mrst_push", 64'(fifo_push), 64'(0));
      check("mrst_ready", 64'(req_ready), 64'(0));
      check("mrst_data", 64'(fifo_data), 64'(0));
      check("mrst_flush", 64'(fifo_flush), 64'(0));
`ifdef FIFO_PUSH_ARB_STATS_EN
      check("mrst_stats", 64'(stat_beats), 64'(0));
`endif
      advance();
      set_beat(1, 1'b1, 1'b1, 32'h610);
      set_beat(3, 1'b1, 1'b1, 32'h630);
      settle();
      check("mrst_first_idx", 64'(grant_idx), 64'(1));
      advance();

      // Random traffic against the model
      clear_inputs();
      for (int i = 0; i < 3000; i++) begin
         step();
         rand_drive();
      end

`ifdef FIFO_PUSH_ARB_STATS_EN
      // Counter saturation on one requester, then clear by flush
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_beat(0, 1'b1, 1'b1, 32'h7);
      repeat (70000) step();
      settle();
      check("sat_req0", 64'(stat_beats[15:0]), 64'(65535));
      check("sat_req1", 64'(stat_beats[31:16]), 64'(0));
      advance();
      flush_req = 1'b1;
      step();
      clear_inputs();
      step();
      step();
      settle();
      check("flush_clr", 64'(stat_beats), 64'(0));
      advance();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
